// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    localparam int unsigned IMEM_ADDR_W = 10;
    localparam int unsigned LEN_W       = 16;

    typedef enum logic [2:0] {
        S_LEN_HI = 3'd0,
        S_LEN_LO = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_FLUSH  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Collects four stream bytes (MSB first) into a 32-bit word; flags the 4th byte.
module imem_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_c,
    output logic        word_done_c
);

    logic [1:0]  cnt;
    logic [23:0] shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= 2'd0;
            shift <= 24'd0;
        end else if (byte_en) begin
            cnt   <= cnt + 2'd1;
            shift <= {shift[15:0], byte_in};
        end
    end

    // The 4th byte completes the word in the same cycle it is accepted.
    assign word_c      = {shift, byte_in};
    assign word_done_c = byte_en && (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> instruction memory writes, holds CPU until done.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [7:0]        RxData,
    input  logic              RxValid,
    output logic              RxReady,
    output logic              ImWe,
    output logic [ADDR_W-1:0] ImAddr,
    output logic [31:0]       ImWData,
    output logic              CpuHold,
    output logic              Done,
    output logic              Error
);

    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam int unsigned CMP_W = (IDX_W > LEN_W + 1) ? IDX_W : LEN_W + 1;
    localparam logic [CMP_W-1:0] MAX_WORDS = CMP_W'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CSUM;
`else
    localparam state_t S_AFTER_DATA = S_FLUSH;
`endif

    state_t             state;
    state_t             next_state;
    logic [7:0]         len_hi;
    logic [LEN_W-1:0]   len;
    logic [IDX_W-1:0]   word_idx;

    logic               accept_c;
    logic [LEN_W-1:0]   len_lo_c;
    logic               last_word_c;
    logic               asm_en_c;
    logic [31:0]        word_c;
    logic               word_done_c;

    assign accept_c    = RxValid && RxReady;
    assign len_lo_c    = {len_hi, RxData};
    assign last_word_c = (CMP_W'(word_idx) + CMP_W'(1)) == CMP_W'(len);
    assign asm_en_c    = accept_c && (state == S_DATA);

    imem_word_assembler u_asm (
        .clk         (Clk),
        .reset       (Reset),
        .byte_en     (asm_en_c),
        .byte_in     (RxData),
        .word_c      (word_c),
        .word_done_c (word_done_c)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic       csum_ok_c;

    assign csum_ok_c = 8'(sum + RxData) == 8'd0;

    // Running sum over the length bytes and every data byte.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sum <= 8'd0;
        end else if (accept_c && (state inside {S_LEN_HI, S_LEN_LO, S_DATA})) begin
            sum <= 8'(sum + RxData);
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_LEN_HI;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_LEN_HI: begin
                if (accept_c) next_state = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept_c) begin
                    if (CMP_W'(len_lo_c) > MAX_WORDS) begin
                        next_state = S_ERR;
                    end else if (len_lo_c == '0) begin
                        next_state = S_AFTER_DATA;
                    end else begin
                        next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_done_c && last_word_c) next_state = S_AFTER_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept_c) next_state = csum_ok_c ? S_FLUSH : S_ERR;
            end
`endif
            S_FLUSH: next_state = S_DONE;
            S_DONE:  next_state = S_DONE;
            S_ERR:   next_state = S_ERR;
            default: next_state = S_ERR;
        endcase
    end

    // Registered outputs follow the state being entered so they line up with it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            len_hi   <= 8'd0;
            len      <= '0;
            word_idx <= '0;
            RxReady  <= 1'b1;
            ImWe     <= 1'b0;
            ImAddr   <= '0;
            ImWData  <= 32'd0;
            CpuHold  <= 1'b1;
            Done     <= 1'b0;
            Error    <= 1'b0;
        end else begin
            RxReady <= next_state inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
            CpuHold <= next_state != S_DONE;
            Done    <= next_state == S_DONE;
            Error   <= next_state == S_ERR;
            ImWe    <= word_done_c;
            if (accept_c && (state == S_LEN_HI)) len_hi <= RxData;
            if (accept_c && (state == S_LEN_LO)) len    <= len_lo_c;
            if (word_done_c) begin
                ImAddr   <= word_idx[ADDR_W-1:0];
                ImWData  <= word_c;
                word_idx <= word_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued by stimulus, popped by a write monitor.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int unsigned ADDR_W = 10;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic [7:0]        RxData = 8'd0;
    logic              RxValid = 1'b0;
    logic              RxReady;
    logic              ImWe;
    logic [ADDR_W-1:0] ImAddr;
    logic [31:0]       ImWData;
    logic              CpuHold;
    logic              Done;
    logic              Error;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] frame[$];
    int         errors = 0;
    int         checks = 0;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .RxData  (RxData),
        .RxValid (RxValid),
        .RxReady (RxReady),
        .ImWe    (ImWe),
        .ImAddr  (ImAddr),
        .ImWData (ImWData),
        .CpuHold (CpuHold),
        .Done    (Done),
        .Error   (Error)
    );

    always #5 Clk = ~Clk;

    // Every write strobe must match the oldest outstanding expected write.
    always @(negedge Clk) begin
        if (ImWe) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write", ImAddr, ImWData);
            end else begin
                mon_e = exp_q.pop_front();
                if (ImAddr !== mon_e.addr || ImWData !== mon_e.data) begin
                    errors++;
                    $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                             ImAddr, ImWData, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_wr(input int addr, input logic [31:0] data);
        wr_t w;
        w.addr = ADDR_W'(addr);
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Reset is held while a byte is offered, so reset must win over the transfer.
    task automatic do_reset();
        Reset   = 1'b1;
        RxValid = 1'b1;
        RxData  = 8'hFF;
        repeat (2) begin @(posedge Clk); #1; end
        Reset   = 1'b0;
        RxValid = 1'b0;
    endtask

    task automatic check_reset_state(input string name);
        chk({name, "_rxready"}, 32'(RxReady), 32'd1);
        chk({name, "_imwe"},    32'(ImWe),    32'd0);
        chk({name, "_imaddr"},  32'(ImAddr),  32'd0);
        chk({name, "_imwdata"}, ImWData,      32'd0);
        chk({name, "_cpuhold"}, 32'(CpuHold), 32'd1);
        chk({name, "_done"},    32'(Done),    32'd0);
        chk({name, "_error"},   32'(Error),   32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit taken;
        if (gaps) begin
            RxValid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge Clk); #1; end
        end
        RxValid = 1'b1;
        RxData  = b;
        taken   = 1'b0;
        for (int t = 0; t < 20 && !taken; t++) begin
            taken = RxReady;
            @(posedge Clk); #1;
        end
        RxValid = 1'b0;
        if (!taken) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: byte %h not accepted within 20 cycles, expected accept", b);
        end
    endtask

    task automatic send_frame(input bit gaps);
        foreach (frame[i]) send_byte(frame[i], gaps);
    endtask

    task automatic add_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] s;
        s = 8'd0;
        foreach (frame[i]) s = 8'(s + frame[i]);
        frame.push_back(8'(8'd0 - s));
`endif
    endtask

    // Called in the cycle right after the last accepted byte (the flush cycle).
    task automatic check_release(input string name);
        chk({name, "_hold_flush"}, 32'(CpuHold), 32'd1);
        chk({name, "_done_flush"}, 32'(Done),    32'd0);
        @(posedge Clk); #1;
        chk({name, "_hold_rel"},   32'(CpuHold), 32'd0);
        chk({name, "_done_rel"},   32'(Done),    32'd1);
        chk({name, "_ready_rel"},  32'(RxReady), 32'd0);
        chk({name, "_error_rel"},  32'(Error),   32'd0);
        repeat (2) begin @(posedge Clk); #1; end
        chk({name, "_drained"},    32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        do_reset();
        check_reset_state("rst0");

        // Two words at full throughput.
        push_wr(0, 32'h12345678);
        push_wr(1, 32'h9ABCDEF0);
        frame = {8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        add_csum();
        send_frame(1'b0);
        check_release("two_word");

        // Empty image.
        do_reset();
        frame = {8'h00, 8'h00};
        add_csum();
        send_frame(1'b0);
        check_release("zero");

        // Word count one past capacity.
        do_reset();
        frame = {8'h04, 8'h01};
        send_frame(1'b0);
        chk("ovf_error",   32'(Error),   32'd1);
        chk("ovf_ready",   32'(RxReady), 32'd0);
        chk("ovf_hold",    32'(CpuHold), 32'd1);
        chk("ovf_done",    32'(Done),    32'd0);
        RxValid = 1'b1;
        RxData  = 8'h55;
        repeat (6) begin @(posedge Clk); #1; end
        RxValid = 1'b0;
        chk("ovf_sticky",  32'(Error),   32'd1);
        chk("ovf_drained", 32'(exp_q.size()), 32'd0);

        // Exactly full capacity: last write lands on the top address.
        do_reset();
        frame = {8'h04, 8'h00};
        for (int i = 0; i < 1024; i++) begin
            push_wr(i, {16'hC0DE, 16'(i)});
            frame.push_back(8'hC0);
            frame.push_back(8'hDE);
            frame.push_back(8'(i >> 8));
            frame.push_back(8'(i));
        end
        add_csum();
        send_frame(1'b0);
        check_release("full");
        chk("full_last_addr", 32'(ImAddr), 32'h3FF);
        chk("full_last_data", ImWData,     32'hC0DE03FF);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reset();
        push_wr(0, 32'h01020304);
        frame = {8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5};
        send_frame(1'b0);
        check_release("csum_good");

        do_reset();
        push_wr(0, 32'h01020304);
        frame = {8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF4};
        send_frame(1'b0);
        chk("csum_bad_error", 32'(Error),   32'd1);
        chk("csum_bad_hold",  32'(CpuHold), 32'd1);
        chk("csum_bad_done",  32'(Done),    32'd0);
        repeat (2) begin @(posedge Clk); #1; end
        chk("csum_bad_drained", 32'(exp_q.size()), 32'd0);
`endif

        // Same two-word frame with random idle gaps between bytes.
        do_reset();
        push_wr(0, 32'h12345678);
        push_wr(1, 32'h9ABCDEF0);
        frame = {8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        add_csum();
        send_frame(1'b1);
        check_release("gaps");

        // Reset after three data bytes, then a fresh single-word frame.
        do_reset();
        frame = {8'h00, 8'h02, 8'h12, 8'h34, 8'h56};
        send_frame(1'b0);
        do_reset();
        check_reset_state("rst_mid");
        push_wr(0, 32'hAABBCCDD);
        frame = {8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        add_csum();
        send_frame(1'b0);
        check_release("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
